frame_checker: RTL and testbench

- Sits directly downstream of the byte de-framer and consumes each completed frame from it: the de-framer's frame byte array, its length, and its stable flag.
- Verifies a 2-byte CRC-16/CCITT-FALSE trailer (poly 0x1021, init 0xFFFF, no reflection, no final XOR, big-endian trailer).
- Good frames have the trailer stripped and the payload is streamed one byte per cycle over a valid/ready interface to the command logic.
- Bad or short frames are dropped and flagged.

---
 rtl/frame_checker_if.sv | 22 ++
 rtl/frame_checker.sv | 141 ++++++++++++++
 tb/tb_frame_checker.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_checker_if.sv
// Payload byte stream from frame_checker to the command logic.
// Master drives data/valid/last, slave drives ready.
interface frame_checker_if;
   logic [7:0] dout;
   logic       dout_valid;
   logic       dout_last;
   logic       dout_ready;

   modport master (
      output dout,
      output dout_valid,
      output dout_last,
      input  dout_ready
   );

   modport slave (
      input  dout,
      input  dout_valid,
      input  dout_last,
      output dout_ready
   );
endinterface

// File: rtl/frame_checker.sv
// Checks the CRC-16/CCITT-FALSE trailer of a de-framed frame and
// streams the stripped payload out; bad or runt frames are flagged.
module frame_checker #(
   parameter int          max_data_bytes = 8,
   parameter logic [15:0] crc_init       = 16'hFFFF
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic [max_data_bytes-1:0][7:0]     din,
   input  logic [$clog2(max_data_bytes):0]    len,
   input  logic                               stable,
   frame_checker_if.master                    out_if,
   output logic                               frame_ok,
   output logic                               frame_err,
   output logic                               busy,
   output logic [7:0]                         drop_count
);

   localparam int LW = $clog2(max_data_bytes) + 1;
   localparam int IW = $clog2(max_data_bytes);

   typedef enum logic [1:0] {
      IDLE,
      CHECK,
      COMPARE,
      EMIT
   } state_t;

   state_t                        state;
   logic                          stable_q;
   logic [LW-1:0]                 len_q;
   logic [LW-1:0]                 idx;
   logic [15:0]                   crc;
   logic [max_data_bytes-1:0][7:0] fbuf;

   logic          capture;
   logic          hs;
   logic [LW-1:0] last_idx;
   logic [LW-1:0] nxt_idx;
   logic [15:0]   trailer;

   function automatic logic [IW-1:0] ix(input logic [LW-1:0] i);
      return i[IW-1:0];
   endfunction

   // 8-bit-parallel CCITT step, MSB first
   function automatic logic [15:0] crc_byte(
      input logic [15:0] c,
      input logic [7:0]  d
   );
      logic [15:0] r;
      r = c ^ {d, 8'h00};
      for (int i = 0; i < 8; i++) begin
         if (r[15]) r = {r[14:0], 1'b0} ^ 16'h1021;
         else       r = {r[14:0], 1'b0};
      end
      return r;
   endfunction

   assign capture  = stable & ~stable_q;
   assign hs       = out_if.dout_valid & out_if.dout_ready;
   assign last_idx = len_q - LW'(3);
   assign nxt_idx  = idx + LW'(1);
   assign trailer  = {fbuf[ix(len_q - LW'(2))],
                      fbuf[ix(len_q - LW'(1))]};
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state             <= IDLE;
         stable_q          <= 1'b1;
         len_q             <= '0;
         idx               <= '0;
         crc               <= crc_init;
         fbuf              <= '0;
         out_if.dout       <= 8'h00;
         out_if.dout_valid <= 1'b0;
         out_if.dout_last  <= 1'b0;
         frame_ok          <= 1'b0;
         frame_err         <= 1'b0;
         drop_count        <= 8'h00;
      end else begin
         stable_q  <= stable;
         frame_ok  <= 1'b0;
         frame_err <= 1'b0;

         if (capture && state != IDLE && drop_count != 8'hFF)
            drop_count <= drop_count + 8'd1;

         unique case (state)
            IDLE: begin
               if (capture) begin
                  fbuf  <= din;
                  len_q <= len;
                  if (len < LW'(3) ||
                      len > LW'(max_data_bytes)) begin
                     frame_err <= 1'b1;
                  end else begin
                     crc   <= crc_init;
                     idx   <= '0;
                     state <= CHECK;
                  end
               end
            end
            CHECK: begin
               crc <= crc_byte(crc, fbuf[ix(idx)]);
               idx <= nxt_idx;
               if (idx == last_idx) state <= COMPARE;
            end
            COMPARE: begin
               if (crc == trailer) begin
                  frame_ok          <= 1'b1;
                  idx               <= '0;
                  out_if.dout       <= fbuf[0];
                  out_if.dout_valid <= 1'b1;
                  out_if.dout_last  <= (last_idx == '0);
                  state             <= EMIT;
               end else begin
                  frame_err <= 1'b1;
                  state     <= IDLE;
               end
            end
            EMIT: begin
               if (hs) begin
                  if (out_if.dout_last) begin
                     out_if.dout_valid <= 1'b0;
                     out_if.dout_last  <= 1'b0;
                     state             <= IDLE;
                  end else begin
                     idx              <= nxt_idx;
                     out_if.dout      <= fbuf[ix(nxt_idx)];
                     out_if.dout_last <= (nxt_idx == last_idx);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_frame_checker.sv
// Randomized bench for frame_checker against a frame-level model:
// a frame is good when the CRC over payload+trailer leaves residue 0.
module tb_frame_checker;

   localparam int MAXB = 16;

   logic              clk;
   logic              reset_n;
   logic [MAXB-1:0][7:0] din;
   logic [4:0]        len;
   logic              stable;
   logic              frame_ok;
   logic              frame_err;
   logic              busy;
   logic [7:0]        drop_count;

   frame_checker_if ifc ();

   frame_checker #(
      .max_data_bytes (MAXB),
      .crc_init       (16'hFFFF)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .din        (din),
      .len        (len),
      .stable     (stable),
      .out_if     (ifc.master),
      .frame_ok   (frame_ok),
      .frame_err  (frame_err),
      .busy       (busy),
      .drop_count (drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errs;
   int checks;
   int exp_drops;

   task automatic check_eq(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // residue of the whole byte string, bit-serial long division
   function automatic logic [15:0] crc_model(
      input logic [7:0] b [MAXB],
      input int         n
   );
      logic [15:0] r;
      logic        fb;
      r = 16'hFFFF;
      for (int i = 0; i < n; i++) begin
         for (int j = 7; j >= 0; j--) begin
            fb = r[15] ^ b[i][j];
            r  = {r[14:0], 1'b0};
            if (fb) r = r ^ 16'h1021;
         end
      end
      return r;
   endfunction

   task automatic make_good(
      input  int         n,
      output logic [7:0] b [MAXB]
   );
      logic [15:0] c;
      for (int i = 0; i < MAXB; i++) b[i] = 8'($urandom);
      c = crc_model(b, n);
      b[n]   = c[15:8];
      b[n+1] = c[7:0];
   endtask

   task automatic run_frame(
      input logic [7:0] b [MAXB],
      input int         ln,
      input int         rmode,
      input bit         inject
   );
      logic [7:0] q [$];
      bit         good;
      bit         runt;
      bit         vseen;
      bit         pend;
      bit         rdy;
      bit         inj_fired;
      logic [7:0] pd;
      logic       pl;
      int         k;
      int         okc;
      int         errc;
      int         ok_at;
      int         err_at;
      int         nacc;
      int         tail;
      int         inj_k;

      runt = (ln < 3 || ln > MAXB);
      good = 1'b0;
      if (!runt) good = (crc_model(b, ln) == 16'h0000);
      if (good)
         for (int i = 0; i < ln - 2; i++) q.push_back(b[i]);

      stable = 1'b0;
      ifc.dout_ready = 1'b0;
      @(negedge clk);
      for (int i = 0; i < MAXB; i++) din[i] = b[i];
      len    = ln[4:0];
      stable = 1'b1;

      k = 0; okc = 0; errc = 0; ok_at = -1; err_at = -1;
      nacc = 0; tail = -1; vseen = 0; pend = 0;
      inj_fired = 0; inj_k = -10; pd = '0; pl = 0;

      while (1) begin
         @(negedge clk);
         k++;
         if (k == 2) stable = 1'b0;
         if (inj_fired && k == inj_k + 1) stable = 1'b0;
         if (frame_ok)  begin okc++;  ok_at  = k; end
         if (frame_err) begin errc++; err_at = k; end
         if (k == 1 && !runt) check_eq("busy_check", busy, 1);
         if (pend) begin
            check_eq("hold_valid", ifc.dout_valid, 1);
            check_eq("hold_data", ifc.dout, pd);
            check_eq("hold_last", ifc.dout_last, pl);
         end
         case (rmode)
            0:       rdy = 1'b1;
            1:       rdy = (k % 3 == 0);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         pend = 0;
         if (ifc.dout_valid) begin
            vseen = 1;
            if (inject && !inj_fired) begin
               stable    = 1'b1;
               inj_fired = 1;
               inj_k     = k;
            end
            if (rdy) begin
               if (nacc < q.size()) begin
                  check_eq("data", ifc.dout, q[nacc]);
                  check_eq("last", ifc.dout_last,
                           32'(nacc == q.size() - 1));
               end else begin
                  check_eq("extra_byte", ifc.dout_valid, 0);
               end
               nacc++;
            end else begin
               pend = 1;
               pd   = ifc.dout;
               pl   = ifc.dout_last;
            end
         end
         ifc.dout_ready = rdy;
         if (tail < 0) begin
            if (!busy && (good ? (okc > 0 && nacc >= q.size())
                               : (errc > 0)))
               tail = 3;
         end else begin
            tail--;
         end
         if (tail == 0) break;
         if (k > 300) begin
            check_eq("timeout", 1, 0);
            break;
         end
      end
      ifc.dout_ready = 1'b0;
      stable = 1'b0;

      if (good) begin
         check_eq("ok_count", okc, 1);
         check_eq("ok_cycle", ok_at, ln);
         check_eq("ok_no_err", errc, 0);
         check_eq("payload_len", nacc, q.size());
      end else begin
         check_eq("err_count", errc, 1);
         check_eq("err_cycle", err_at, runt ? 1 : ln);
         check_eq("err_no_ok", okc, 0);
         check_eq("err_no_valid", vseen, 0);
      end
      if (inject && inj_fired && exp_drops < 255) exp_drops++;
      check_eq("busy_end", busy, 0);
      check_eq("drops", drop_count, exp_drops);
   endtask

   logic [7:0] fr [MAXB];

   task automatic load_ref(input logic [7:0] t1);
      for (int i = 0; i < MAXB; i++) fr[i] = 8'h00;
      for (int i = 0; i < 9; i++) fr[i] = 8'h31 + 8'(i);
      fr[9]  = 8'h29;
      fr[10] = t1;
   endtask

   initial begin
      errs = 0; checks = 0; exp_drops = 0;
      reset_n = 1'b0;
      stable  = 1'b0;
      din     = '0;
      len     = '0;
      ifc.dout_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_valid", ifc.dout_valid, 0);
      check_eq("rst_dout", ifc.dout, 0);
      check_eq("rst_last", ifc.dout_last, 0);
      check_eq("rst_ok", frame_ok, 0);
      check_eq("rst_err", frame_err, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_drops", drop_count, 0);
      reset_n = 1'b1;
      @(negedge clk);

      load_ref(8'hB1);
      run_frame(fr, 11, 0, 0);
      load_ref(8'hB0);
      run_frame(fr, 11, 0, 0);

      for (int i = 0; i < MAXB; i++) fr[i] = 8'hFF;
      run_frame(fr, 2, 0, 0);
      run_frame(fr, 0, 0, 0);
      run_frame(fr, 17, 0, 0);

      load_ref(8'hB1);
      run_frame(fr, 11, 1, 0);
      run_frame(fr, 11, 0, 1);
      run_frame(fr, 11, 0, 0);

      make_good(1, fr);
      run_frame(fr, 3, 0, 1);
      make_good(14, fr);
      run_frame(fr, 16, 2, 0);

      // reset while the reference frame is still in CHECK
      load_ref(8'hB1);
      @(negedge clk);
      for (int i = 0; i < MAXB; i++) din[i] = fr[i];
      len    = 5'd11;
      stable = 1'b1;
      repeat (3) @(negedge clk);
      stable = 1'b0;
      check_eq("mid_busy", busy, 1);
      reset_n = 1'b0;
      #1;
      check_eq("mid_rst_busy", busy, 0);
      check_eq("mid_rst_valid", ifc.dout_valid, 0);
      check_eq("mid_rst_ok", frame_ok, 0);
      check_eq("mid_rst_err", frame_err, 0);
      check_eq("mid_rst_drops", drop_count, 0);
      check_eq("mid_rst_dout", ifc.dout, 0);
      @(negedge clk);
      reset_n   = 1'b1;
      exp_drops = 0;
      run_frame(fr, 11, 0, 0);

      for (int n = 0; n < 24; n++) begin
         int pl_n;
         int ln;
         pl_n = $urandom_range(1, MAXB - 2);
         make_good(pl_n, fr);
         ln = pl_n + 2;
         case ($urandom_range(0, 5))
            0: fr[$urandom_range(0, ln - 1)] ^=
                  8'(1 << $urandom_range(0, 7));
            1: ln = $urandom_range(0, 2);
            default: ;
         endcase
         run_frame(fr, ln, $urandom_range(0, 2),
                   ($urandom_range(0, 3) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
